// File: rtl/mc_sample_pkg.sv
// rtl/mc_sample_pkg.sv - states, seed constants and LFSR tap table for the sample source
package mc_sample_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Power-on LFSR states; each is truncated to the LFSR width at use.
    localparam logic [32:0] SEED_X = 33'h0_0000_0155;
    localparam logic [32:0] SEED_Y = 33'h0_0000_02A3;
    localparam logic [32:0] SEED_T = 33'h0_0001_5A5B;

    // Per-LFSR whitening so that a single user seed gives three distinct streams.
    localparam logic [32:0] K_X = 33'h0_1357_9BDF;
    localparam logic [32:0] K_Y = 33'h0_2468_ACE1;
    localparam logic [32:0] K_T = 33'h0_0F0F_3C3D;

    // Galois (right-shift) feedback masks of maximal-length polynomials.
    function automatic logic [32:0] lfsr_taps(input int w);
        case (w)
            3:       return 33'h0_0000_0006;
            4:       return 33'h0_0000_000C;
            5:       return 33'h0_0000_0014;
            6:       return 33'h0_0000_0030;
            7:       return 33'h0_0000_0060;
            8:       return 33'h0_0000_00B8;
            9:       return 33'h0_0000_0110;
            10:      return 33'h0_0000_0240;
            11:      return 33'h0_0000_0500;
            12:      return 33'h0_0000_0829;
            13:      return 33'h0_0000_100D;
            14:      return 33'h0_0000_2015;
            15:      return 33'h0_0000_6000;
            16:      return 33'h0_0000_D008;
            17:      return 33'h0_0001_2000;
            18:      return 33'h0_0002_0400;
            19:      return 33'h0_0004_0023;
            20:      return 33'h0_0009_0000;
            21:      return 33'h0_0014_0000;
            22:      return 33'h0_0030_0000;
            23:      return 33'h0_0042_0000;
            24:      return 33'h0_00E1_0000;
            25:      return 33'h0_0120_0000;
            26:      return 33'h0_0200_0023;
            27:      return 33'h0_0400_0013;
            28:      return 33'h0_0900_0000;
            29:      return 33'h0_1400_0000;
            30:      return 33'h0_2000_0029;
            31:      return 33'h0_4800_0000;
            32:      return 33'h0_8020_0003;
            33:      return 33'h1_0008_0000;
            default: return 33'h0_0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/mc_lfsr.sv
// rtl/mc_lfsr.sv - Galois LFSR with load and advance controls
// Ports: clk, rst_n (async, active-low); advance steps once; load takes load_val
// (an all-zero load_val falls back to DEFAULT_SEED); state is the current register.
module mc_lfsr
    import mc_sample_pkg::*;
#(
    parameter int           W            = 10,
    parameter logic [W-1:0] DEFAULT_SEED = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            // All-zero is the lock-up state of an XOR LFSR.
            state_d = (load_val == '0) ? DEFAULT_SEED : load_val;
        end else if (advance) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DEFAULT_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/mc_sample_source.sv
// rtl/mc_sample_source.sv - scaled random (x, y, t) sample producer with 2-entry output buffer
// Ports: clk, rst_n (async, active-low); start/abort/load_seed/seed control a run;
// num_samples, x/y bounds and t_max are latched at start; sample_valid/sample_ready
// handshake sample_x/sample_y/sample_t; busy in RUN, done in DONE.
module mc_sample_source
    import mc_sample_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             load_seed,
    input  logic [2*WIDTH:0] seed,
    input  logic [WIDTH-1:0] num_samples,
    input  logic [WIDTH-1:0] x_begin,
    input  logic [WIDTH-1:0] x_end,
    input  logic [WIDTH-1:0] y_begin,
    input  logic [WIDTH-1:0] y_end,
    input  logic [2*WIDTH:0] t_max,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [WIDTH-1:0] sample_x,
    output logic [WIDTH-1:0] sample_y,
    output logic [2*WIDTH:0] sample_t,
    output logic             busy,
    output logic             done
);

    localparam int TW = 2 * WIDTH + 1;

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          num_q, num_d, xb_q, xb_d, xe_q, xe_d, yb_q, yb_d, ye_q, ye_d;
    logic [TW-1:0]             tmax_q, tmax_d;
    logic [WIDTH-1:0]          gen_q, gen_d, dlv_q, dlv_d;
    logic                      inflight_q, inflight_d;
    logic [1:0]                occ_q, occ_d;
    logic                      wr_q, wr_d, rd_q, rd_d;
    logic [1:0][WIDTH-1:0]     bx_q, bx_d, by_q, by_d;
    logic [1:0][TW-1:0]        bt_q, bt_d;

    logic                      gen, ld, pop;
    logic [2:0]                fill;
    logic [WIDTH-1:0]          raw_x, raw_y, span_x, span_y, sx, sy;
    logic [TW-1:0]             raw_t, st;
    logic [2*WIDTH-1:0]        prod_x, prod_y;
    logic [2*TW-1:0]           prod_t;

    mc_lfsr #(.W(WIDTH), .DEFAULT_SEED(WIDTH'(SEED_X))) u_lfsr_x (
        .clk(clk), .rst_n(rst_n), .advance(gen), .load(ld),
        .load_val(WIDTH'(seed ^ TW'(K_X))), .state(raw_x)
    );
    mc_lfsr #(.W(WIDTH), .DEFAULT_SEED(WIDTH'(SEED_Y))) u_lfsr_y (
        .clk(clk), .rst_n(rst_n), .advance(gen), .load(ld),
        .load_val(WIDTH'(seed ^ TW'(K_Y))), .state(raw_y)
    );
    mc_lfsr #(.W(TW), .DEFAULT_SEED(TW'(SEED_T))) u_lfsr_t (
        .clk(clk), .rst_n(rst_n), .advance(gen), .load(ld),
        .load_val(seed ^ TW'(K_T)), .state(raw_t)
    );

    // The LFSRs advance on the generate edge, so during the in-flight cycle their
    // outputs already hold this sample's raw values; scaling is combinational.
    assign span_x = (xe_q > xb_q) ? xe_q - xb_q : '0;
    assign span_y = (ye_q > yb_q) ? ye_q - yb_q : '0;
    assign prod_x = {{WIDTH{1'b0}}, raw_x} * {{WIDTH{1'b0}}, span_x};
    assign prod_y = {{WIDTH{1'b0}}, raw_y} * {{WIDTH{1'b0}}, span_y};
    assign prod_t = {{TW{1'b0}}, raw_t} * {{TW{1'b0}}, tmax_q};
    assign sx     = xb_q + WIDTH'(prod_x >> WIDTH);
    assign sy     = yb_q + WIDTH'(prod_y >> WIDTH);
    assign st     = TW'(prod_t >> TW);

    assign sample_valid = (state_q == ST_RUN) && (occ_q != 2'd0);
    assign pop          = sample_valid & sample_ready;
    assign sample_x     = sample_valid ? bx_q[rd_q] : '0;
    assign sample_y     = sample_valid ? by_q[rd_q] : '0;
    assign sample_t     = sample_valid ? bt_q[rd_q] : '0;
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);

    // Occupancy after this edge if nothing new were generated; also the next occupancy.
    assign fill = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        xb_d       = xb_q;
        xe_d       = xe_q;
        yb_d       = yb_q;
        ye_d       = ye_q;
        tmax_d     = tmax_q;
        gen_d      = gen_q;
        dlv_d      = dlv_q;
        inflight_d = inflight_q;
        occ_d      = occ_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        bx_d       = bx_q;
        by_d       = by_q;
        bt_d       = bt_q;
        gen        = 1'b0;
        ld         = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            gen_d      = '0;
            dlv_d      = '0;
            inflight_d = 1'b0;
            occ_d      = 2'd0;
            wr_d       = 1'b0;
            rd_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        num_d   = num_samples;
                        xb_d    = x_begin;
                        xe_d    = x_end;
                        yb_d    = y_begin;
                        ye_d    = y_end;
                        tmax_d  = t_max;
                        gen_d   = '0;
                        dlv_d   = '0;
                        ld      = load_seed;
                        state_d = (num_samples == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    gen        = (gen_q < num_q) && (fill < 3'(BUF_DEPTH));
                    inflight_d = gen;
                    gen_d      = gen_q + WIDTH'(gen);
                    occ_d      = fill[1:0];
                    if (inflight_q) begin
                        bx_d[wr_q] = sx;
                        by_d[wr_q] = sy;
                        bt_d[wr_q] = st;
                        wr_d       = ~wr_q;
                    end
                    if (pop) begin
                        rd_d  = ~rd_q;
                        dlv_d = dlv_q + WIDTH'(1);
                    end
                    if (dlv_d == num_q) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            xb_q       <= '0;
            xe_q       <= '0;
            yb_q       <= '0;
            ye_q       <= '0;
            tmax_q     <= '0;
            gen_q      <= '0;
            dlv_q      <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            bx_q       <= '0;
            by_q       <= '0;
            bt_q       <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            xb_q       <= xb_d;
            xe_q       <= xe_d;
            yb_q       <= yb_d;
            ye_q       <= ye_d;
            tmax_q     <= tmax_d;
            gen_q      <= gen_d;
            dlv_q      <= dlv_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            bt_q       <= bt_d;
        end
    end

endmodule

// File: tb/tb_mc_sample_source.sv
// tb/tb_mc_sample_source.sv - scoreboard bench for mc_sample_source
module tb_mc_sample_source;
    import mc_sample_pkg::*;

    localparam int W  = 10;
    localparam int TW = 2 * W + 1;
    localparam logic [W-1:0]  MASK_XY = 10'h240;
    localparam logic [TW-1:0] MASK_T  = 21'h140000;

    typedef struct packed {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [TW-1:0] t;
    } smp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, load_seed = 1'b0, sample_ready = 1'b0;
    logic [TW-1:0] seed = '0, t_max = '0;
    logic [W-1:0]  num_samples = '0, x_begin = '0, x_end = '0, y_begin = '0, y_end = '0;
    logic          sample_valid, busy, done;
    logic [W-1:0]  sample_x, sample_y;
    logic [TW-1:0] sample_t;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   dlv_cnt = 0;
    logic sb_on = 1'b1;
    smp_t exp_q[$];
    smp_t obs_q[$];
    logic [W-1:0]  mx, my;
    logic [TW-1:0] mt;

    always #5 clk = ~clk;

    mc_sample_source #(.WIDTH(W), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .load_seed(load_seed),
        .seed(seed), .num_samples(num_samples), .x_begin(x_begin), .x_end(x_end),
        .y_begin(y_begin), .y_end(y_end), .t_max(t_max), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_x(sample_x), .sample_y(sample_y),
        .sample_t(sample_t), .busy(busy), .done(done)
    );

    function automatic logic [W-1:0] step_xy(input logic [W-1:0] s);
        return s[0] ? ((s >> 1) ^ MASK_XY) : (s >> 1);
    endfunction

    function automatic logic [TW-1:0] step_t(input logic [TW-1:0] s);
        return s[0] ? ((s >> 1) ^ MASK_T) : (s >> 1);
    endfunction

    function automatic logic [W-1:0] ref_xy(input logic [W-1:0] r, input logic [W-1:0] b,
                                             input logic [W-1:0] e);
        logic [31:0] span, p;
        span = (e > b) ? 32'(e) - 32'(b) : 32'd0;
        p    = 32'(r) * span;
        return W'(32'(b) + p / 1024);
    endfunction

    function automatic logic [TW-1:0] ref_t(input logic [TW-1:0] r, input logic [TW-1:0] tm);
        logic [63:0] p;
        p = 64'(r) * 64'(tm);
        return TW'(p / 64'(2097152));
    endfunction

    // Scoreboard monitor: pops one expected sample per handshake, checks stall stability.
    always begin : monitor
        smp_t e, got, prev_s;
        logic stall_prev;
        stall_prev = 1'b0;
        prev_s = '0;
        forever begin
            @(negedge clk);
            #1;
            got.x = sample_x;
            got.y = sample_y;
            got.t = sample_t;
            if (sb_on && rst_n) begin
                if (stall_prev) begin
                    total_cnt++;
                    if (sample_valid !== 1'b1 || got !== prev_s)
                        $display("FAIL stall_stable: got v=%0b %h required v=1 %h", sample_valid, got, prev_s);
                    else
                        pass_cnt++;
                end
                if (sample_valid && sample_ready) begin
                    total_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_extra: got %h with no expected sample", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e)
                            $display("FAIL sb_sample: got %h required %h", got, e);
                        else
                            pass_cnt++;
                    end
                    dlv_cnt++;
                    obs_q.push_back(got);
                end
                stall_prev = sample_valid && !sample_ready;
                prev_s = got;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic start_run(input logic ld, input logic [TW-1:0] sd, input logic [W-1:0] n,
                             input logic [W-1:0] xb, input logic [W-1:0] xe,
                             input logic [W-1:0] yb, input logic [W-1:0] ye,
                             input logic [TW-1:0] tm);
        smp_t s;
        @(negedge clk);
        load_seed = ld; seed = sd; num_samples = n; t_max = tm;
        x_begin = xb; x_end = xe; y_begin = yb; y_end = ye;
        start = 1'b1;
        dlv_cnt = 0;
        exp_q.delete();
        obs_q.delete();
        if (ld) begin
            mx = W'(sd ^ TW'(K_X));
            my = W'(sd ^ TW'(K_Y));
            mt = sd ^ TW'(K_T);
            if (mx == '0) mx = W'(SEED_X);
            if (my == '0) my = W'(SEED_Y);
            if (mt == '0) mt = TW'(SEED_T);
        end
        for (int i = 0; i < int'(n); i++) begin
            mx = step_xy(mx);
            my = step_xy(my);
            mt = step_t(mt);
            s.x = ref_xy(mx, xb, xe);
            s.y = ref_xy(my, yb, ye);
            s.t = ref_t(mt, tm);
            exp_q.push_back(s);
        end
        @(negedge clk);
        start = 1'b0;
        load_seed = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        for (int c = 0; c < budget && !done; c++) @(negedge clk);
        ok = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({sample_valid, busy, done} !== 3'b000)
            $display("FAIL reset_flags: got v/b/d=%b required 000", {sample_valid, busy, done});
        else pass_cnt++;
        total_cnt++;
        if ({sample_x, sample_y, sample_t} !== '0)
            $display("FAIL reset_data: got %h required 0", {sample_x, sample_y, sample_t});
        else pass_cnt++;
        rst_n = 1'b1;
        mx = W'(SEED_X);
        my = W'(SEED_Y);
        mt = TW'(SEED_T);
    endtask

    task automatic test_basic();
        start_run(1'b1, 21'h1ABCD, 10'd5, 10'd0, 10'd1000, 10'd100, 10'd900, 21'h100000);
        total_cnt++;
        if (sample_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL lat_edge1: got v=%0b busy=%0b required v=0 busy=1", sample_valid, busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (sample_valid !== 1'b0) $display("FAIL lat_edge2: got v=%0b required 0", sample_valid);
        else pass_cnt++;
        @(negedge clk);
        sample_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (sample_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %0b required 1", i, sample_valid);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if ({done, busy, sample_valid} !== 3'b100)
            $display("FAIL basic_done: got d/b/v=%b required 100", {done, busy, sample_valid});
        else pass_cnt++;
        total_cnt++;
        if (dlv_cnt !== 5 || exp_q.size() != 0)
            $display("FAIL basic_count: got %0d left %0d required 5 left 0", dlv_cnt, exp_q.size());
        else pass_cnt++;
        sample_ready = 1'b0;
    endtask

    task automatic test_scaling();
        logic ok;
        logic [TW-1:0] sd;
        // Seed chosen so the x LFSR loads 0x081, whose next state is 512.
        sd = TW'(K_X) ^ 21'h000081;
        start_run(1'b1, sd, 10'd3, 10'd100, 10'd300, 10'd50, 10'd50, 21'd0);
        sample_ready = 1'b1;
        wait_done(50, ok);
        total_cnt++;
        if (!ok) $display("FAIL scale_timeout: got done=0 required 1");
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != 3 || obs_q[0].x !== 10'd200)
            $display("FAIL scale_x512: got n=%0d x=%0d required n=3 x=200", obs_q.size(), obs_q.size() ? obs_q[0].x : 10'd0);
        else pass_cnt++;
        for (int i = 0; i < obs_q.size(); i++) begin
            total_cnt++;
            if (obs_q[i].y !== 10'd50 || obs_q[i].t !== '0)
                $display("FAIL scale_zero_span[%0d]: got y=%0d t=%0d required y=50 t=0", i, obs_q[i].y, obs_q[i].t);
            else pass_cnt++;
        end
        sample_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int c;
        start_run(1'b0, '0, 10'd8, 10'd10, 10'd1000, 10'd0, 10'd1023, 21'h1FFFFF);
        for (c = 0; c < 200 && !done; c++) begin
            sample_ready = (c % 4 == 0) || (c % 4 == 3);
            @(negedge clk);
        end
        sample_ready = 1'b0;
        total_cnt++;
        if (!done) $display("FAIL bp_timeout: got done=0 required 1");
        else pass_cnt++;
        total_cnt++;
        if (dlv_cnt !== 8 || exp_q.size() != 0)
            $display("FAIL bp_count: got %0d left %0d required 8 left 0", dlv_cnt, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_zero();
        logic seen;
        seen = 1'b0;
        start_run(1'b1, 21'h00005, 10'd0, 10'd0, 10'd100, 10'd0, 10'd100, 21'd100);
        sample_ready = 1'b1;
        total_cnt++;
        if ({done, busy, sample_valid} !== 3'b100)
            $display("FAIL zero_done: got d/b/v=%b required 100", {done, busy, sample_valid});
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (sample_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (seen || dlv_cnt != 0) $display("FAIL zero_novalid: got seen=%0b n=%0d required 0 0", seen, dlv_cnt);
        else pass_cnt++;
        sample_ready = 1'b0;
    endtask

    task automatic test_reseed();
        logic ok;
        smp_t a[$];
        logic [W-1:0] want_x;
        start_run(1'b1, '0, 10'd4, 10'd0, 10'd1023, 10'd0, 10'd1023, 21'h1FFFFF);
        sample_ready = 1'b1;
        wait_done(50, ok);
        a = obs_q;
        start_run(1'b1, '0, 10'd4, 10'd0, 10'd1023, 10'd0, 10'd1023, 21'h1FFFFF);
        sample_ready = 1'b1;
        wait_done(50, ok);
        total_cnt++;
        if (!ok || obs_q.size() != 4 || a.size() != 4)
            $display("FAIL reseed_len: got done=%0b n=%0d/%0d required 1 4/4", ok, a.size(), obs_q.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < obs_q.size() && i < a.size(); i++) begin
            total_cnt++;
            if (obs_q[i] !== a[i]) $display("FAIL reseed_repeat[%0d]: got %h required %h", i, obs_q[i], a[i]);
            else pass_cnt++;
        end
        start_run(1'b1, TW'(K_X), 10'd2, 10'd0, 10'd1023, 10'd0, 10'd1023, 21'h1FFFFF);
        sample_ready = 1'b1;
        wait_done(50, ok);
        want_x = ref_xy(step_xy(W'(SEED_X)), 10'd0, 10'd1023);
        total_cnt++;
        if (!ok || obs_q.size() != 2 || obs_q[0].x !== want_x)
            $display("FAIL zero_guard: got n=%0d x=%0h required n=2 x=%0h", obs_q.size(), obs_q.size() ? obs_q[0].x : 10'd0, want_x);
        else pass_cnt++;
        sample_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic ok;
        int c;
        start_run(1'b1, 21'h00777, 10'd10, 10'd20, 10'd700, 10'd5, 10'd900, 21'h0ABCDE);
        sample_ready = 1'b1;
        for (c = 0; c < 50 && dlv_cnt < 3; c++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sample_ready = 1'b0;
        total_cnt++;
        if (c >= 50 || {sample_valid, done, busy} !== 3'b000)
            $display("FAIL abort_idle: got v/d/b=%b c=%0d required 000", {sample_valid, done, busy}, c);
        else pass_cnt++;

        start_run(1'b1, 21'h00333, 10'd10, 10'd0, 10'd999, 10'd7, 10'd77, 21'h012345);
        sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1; load_seed = 1'b1; seed = 21'h01555; num_samples = 10'd3;
        @(negedge clk);
        start = 1'b0; load_seed = 1'b0;
        wait_done(100, ok);
        total_cnt++;
        if (!ok || dlv_cnt !== 10 || exp_q.size() != 0)
            $display("FAIL start_ignored: got done=%0b n=%0d left=%0d required 1 10 0", ok, dlv_cnt, exp_q.size());
        else pass_cnt++;

        start_run(1'b1, 21'h00999, 10'd10, 10'd0, 10'd500, 10'd0, 10'd500, 21'h000FFF);
        sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        sb_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({sample_valid, busy, done} !== 3'b000 || {sample_x, sample_y, sample_t} !== '0)
            $display("FAIL async_reset: got v/b/d=%b data=%h required 000 0", {sample_valid, busy, done}, {sample_x, sample_y, sample_t});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        sb_on = 1'b1;
        mx = W'(SEED_X);
        my = W'(SEED_Y);
        mt = TW'(SEED_T);
        start_run(1'b0, '0, 10'd3, 10'd1, 10'd1001, 10'd2, 10'd1002, 21'h1F0F0F);
        wait_done(50, ok);
        total_cnt++;
        if (!ok || dlv_cnt !== 3 || exp_q.size() != 0)
            $display("FAIL default_seed_run: got done=%0b n=%0d left=%0d required 1 3 0", ok, dlv_cnt, exp_q.size());
        else pass_cnt++;
        sample_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scaling();
        test_backpressure();
        test_zero();
        test_reseed();
        test_abort();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish before 500000");
        $fatal(1);
    end

endmodule
